hsci_slave_responder: RTL and testbench

Slave-side responder for the HSCI link, clocked by `hsci_pclk`.
- Consumes the byte-per-cycle MOSI stream produced by the master encoder and parses command frames.
- Performs single register reads and writes on a simple strobe/ack register port.
- Returns a response frame on the MISO byte lane.
- Used as the on-board slave emulation and as the loopback partner for master link bring-up.

---
 rtl/hsci_slave_pkg.sv | 43 ++++
 rtl/hsci_slave_rsp_ser.sv | 70 +++++++
 rtl/hsci_slave_responder.sv | 200 ++++++++++++++++++++
 tb/tb_hsci_slave_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsci_slave_pkg.sv
// Shared definitions for the HSCI slave responder: FSM states, framing
// constants, CMD field positions, STATUS bit indices and the tsize decode.
package hsci_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_PAR,
        ST_EXEC,
        ST_WAIT_ACK,
        ST_RSP_HDR,
        ST_RSP_STAT,
        ST_RSP_DATA,
        ST_RSP_PAR
    } state_e;

    localparam logic [7:0] SOF     = 8'hA5;
    localparam logic [7:0] RSP_HDR = 8'h5A;

    // CMD byte layout
    localparam int CMD_RD_BIT    = 7;
    localparam int CMD_RSVD_MSB  = 6;
    localparam int CMD_RSVD_LSB  = 2;
    localparam int CMD_TSIZE_MSB = 1;
    localparam int CMD_TSIZE_LSB = 0;

    // STATUS byte layout
    localparam int STAT_PAR_ERR = 0;
    localparam int STAT_UNKNOWN = 1;
    localparam int STAT_TIMEOUT = 2;

    // tsize 2 and 3 both move a full 32-bit word
    function automatic logic [2:0] tsize_bytes(input logic [1:0] tsize);
        case (tsize)
            2'd0:    tsize_bytes = 3'd1;
            2'd1:    tsize_bytes = 3'd2;
            default: tsize_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/hsci_slave_rsp_ser.sv
// Response serializer: on load it emits HDR immediately, then STATUS,
// nbytes of data (MSB first) and PAR, one byte per cycle, then idles at 0x00.
// Data is forced to zero whenever STATUS is non-zero.
module hsci_slave_rsp_ser
    import hsci_slave_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  status,
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [7:0]  miso_data
);

    logic [3:0]  cnt;
    logic        stat_pend;
    logic [7:0]  stat_q;
    logic [7:0]  par_q;
    logic [31:0] sh;
    logic [31:0] aligned;
    logic [7:0]  data_xor;

    // Left-justify the response data so bytes can be shifted out from the top
    always_comb begin
        aligned = '0;
        if (status == 8'h00) begin
            case (nbytes)
                3'd1:    aligned = {data[7:0], 24'h0};
                3'd2:    aligned = {data[15:0], 16'h0};
                3'd4:    aligned = data;
                default: aligned = '0;
            endcase
        end
        data_xor = aligned[31:24] ^ aligned[23:16] ^ aligned[15:8] ^ aligned[7:0];
    end

    // Down-counter walks STATUS, data bytes and PAR after the header
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            stat_pend <= 1'b0;
            stat_q    <= '0;
            par_q     <= '0;
            sh        <= '0;
            miso_data <= '0;
        end else if (load) begin
            miso_data <= RSP_HDR;
            cnt       <= {1'b0, nbytes} + 4'd2;
            stat_pend <= 1'b1;
            stat_q    <= status;
            par_q     <= status ^ data_xor;
            sh        <= aligned;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (stat_pend) begin
                miso_data <= stat_q;
                stat_pend <= 1'b0;
            end else if (cnt > 4'd1) begin
                miso_data <= sh[31:24];
                sh        <= {sh[23:0], 8'h00};
            end else begin
                miso_data <= par_q;
            end
        end else begin
            miso_data <= 8'h00;
        end
    end

endmodule

// File: rtl/hsci_slave_responder.sv
// HSCI slave responder: parses MOSI command frames, performs one register
// access on the strobe/ack port and returns a MISO response frame.
// Optional build macro HSCI_SLAVE_ERR_CNT_EN adds the saturating parity
// error counter; without it parity_err_cnt is tied to zero.
//
// Register port handshake: reg_wr/reg_rd is a single-cycle request; the
// target answers with reg_ack (reg_rdata valid in that same cycle) at any
// later cycle. reg_addr/reg_wdata/reg_tsize hold steady until the next
// request. An ack is only honoured while an access is outstanding.
module hsci_slave_responder
    import hsci_slave_pkg::*;
#(
    parameter int ADDR_BYTES  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        hsci_pclk,
    input  logic        hsci_rstn,
    input  logic [7:0]  mosi_data,
    output logic [7:0]  miso_data,
    output logic [31:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic [1:0]  reg_tsize,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic        reg_ack,
    input  logic [31:0] reg_rdata,
    output logic        busy,
    output logic [15:0] parity_err_cnt
);

    localparam logic [2:0]  ADDR_LAST = 3'(ADDR_BYTES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

    state_e      state;
    logic [2:0]  cnt;
    logic        rd_q;
    logic        unk_q;
    logic [1:0]  tsize_q;
    logic [7:0]  xor_q;
    logic [31:0] addr_sh;
    logic [31:0] wdata_sh;
    logic [15:0] tmo_cnt;

    logic [2:0]  frame_bytes;
    logic [2:0]  rsp_bytes;
    logic        par_err;
    logic        tmo_hit;
    logic        ser_load;
    logic [7:0]  ser_status;
    logic [31:0] ser_data;

    assign frame_bytes = tsize_bytes(tsize_q);
    assign rsp_bytes   = rd_q ? frame_bytes : 3'd0;
    assign par_err     = (state == ST_PAR) && (mosi_data != xor_q);
    assign tmo_hit     = (state == ST_WAIT_ACK) && !reg_ack && (tmo_cnt == TMO_LAST);
    assign busy        = (state != ST_IDLE);

    // Start the response in the same edge that leaves PAR or WAIT_ACK
    always_comb begin
        ser_load   = 1'b0;
        ser_status = 8'h00;
        ser_data   = 32'h0;
        if (state == ST_PAR && (par_err || unk_q)) begin
            ser_load                 = 1'b1;
            ser_status[STAT_PAR_ERR] = par_err;
            ser_status[STAT_UNKNOWN] = unk_q;
        end else if (state == ST_WAIT_ACK && reg_ack) begin
            ser_load = 1'b1;
            ser_data = reg_rdata;
        end else if (tmo_hit) begin
            ser_load                 = 1'b1;
            ser_status[STAT_TIMEOUT] = 1'b1;
        end
    end

    // Frame parser, register access and response sequencing
    always_ff @(posedge hsci_pclk or negedge hsci_rstn) begin
        if (!hsci_rstn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rd_q      <= 1'b0;
            unk_q     <= 1'b0;
            tsize_q   <= '0;
            xor_q     <= '0;
            addr_sh   <= '0;
            wdata_sh  <= '0;
            tmo_cnt   <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_tsize <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mosi_data == SOF) state <= ST_CMD;
                end
                ST_CMD: begin
                    rd_q     <= mosi_data[CMD_RD_BIT];
                    tsize_q  <= mosi_data[CMD_TSIZE_MSB:CMD_TSIZE_LSB];
                    unk_q    <= |mosi_data[CMD_RSVD_MSB:CMD_RSVD_LSB];
                    xor_q    <= mosi_data;
                    addr_sh  <= '0;
                    wdata_sh <= '0;
                    cnt      <= ADDR_LAST;
                    state    <= ST_ADDR;
                end
                ST_ADDR: begin
                    addr_sh <= {addr_sh[23:0], mosi_data};
                    xor_q   <= xor_q ^ mosi_data;
                    if (cnt == 3'd0) begin
                        if (rd_q) begin
                            state <= ST_PAR;
                        end else begin
                            cnt   <= frame_bytes - 3'd1;
                            state <= ST_DATA;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_DATA: begin
                    wdata_sh <= {wdata_sh[23:0], mosi_data};
                    xor_q    <= xor_q ^ mosi_data;
                    if (cnt == 3'd0) state <= ST_PAR;
                    else             cnt   <= cnt - 3'd1;
                end
                ST_PAR: begin
                    if (!par_err && !unk_q) begin
                        reg_addr  <= addr_sh;
                        reg_wdata <= wdata_sh;
                        reg_tsize <= tsize_q;
                        reg_wr    <= !rd_q;
                        reg_rd    <= rd_q;
                        state     <= ST_EXEC;
                    end else begin
                        state <= ST_RSP_HDR;
                    end
                end
                ST_EXEC: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (reg_ack || tmo_hit) state   <= ST_RSP_HDR;
                    else                    tmo_cnt <= tmo_cnt + 16'd1;
                end
                ST_RSP_HDR: begin
                    state <= ST_RSP_STAT;
                end
                ST_RSP_STAT: begin
                    if (rsp_bytes == 3'd0) begin
                        state <= ST_RSP_PAR;
                    end else begin
                        cnt   <= rsp_bytes - 3'd1;
                        state <= ST_RSP_DATA;
                    end
                end
                ST_RSP_DATA: begin
                    if (cnt == 3'd0) state <= ST_RSP_PAR;
                    else             cnt   <= cnt - 3'd1;
                end
                ST_RSP_PAR: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HSCI_SLAVE_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Count frames whose PAR byte mismatched, holding at all-ones
    always_ff @(posedge hsci_pclk or negedge hsci_rstn) begin
        if (!hsci_rstn) begin
            err_cnt_q <= '0;
        end else if (par_err && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign parity_err_cnt = err_cnt_q;
`else
    assign parity_err_cnt = 16'h0000;
`endif

    hsci_slave_rsp_ser u_rsp_ser (
        .clk       (hsci_pclk),
        .rst_n     (hsci_rstn),
        .load      (ser_load),
        .status    (ser_status),
        .data      (ser_data),
        .nbytes    (rsp_bytes),
        .miso_data (miso_data)
    );

endmodule

// File: tb/tb_hsci_slave_responder.sv
// Bench for hsci_slave_responder: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_hsci_slave_responder;

  localparam int ADDR_BYTES = 4;
  localparam int TO         = 20;

  logic        hsci_pclk = 1'b0;
  logic        hsci_rstn = 1'b0;
  logic [7:0]  mosi_data = 8'h00;
  logic        reg_ack   = 1'b0;
  logic [31:0] reg_rdata = 32'h0;
  logic [7:0]  miso_data;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [1:0]  reg_tsize;
  logic        reg_wr;
  logic        reg_rd;
  logic        busy;
  logic [15:0] parity_err_cnt;

  int total = 0;
  int bad   = 0;
  int exp_perr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];

  hsci_slave_responder #(.ADDR_BYTES(ADDR_BYTES), .TIMEOUT_CYC(TO)) dut (
    .hsci_pclk      (hsci_pclk),
    .hsci_rstn      (hsci_rstn),
    .mosi_data      (mosi_data),
    .miso_data      (miso_data),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_tsize      (reg_tsize),
    .reg_wr         (reg_wr),
    .reg_rd         (reg_rd),
    .reg_ack        (reg_ack),
    .reg_rdata      (reg_rdata),
    .busy           (busy),
    .parity_err_cnt (parity_err_cnt)
  );

  // clock
  always #5 hsci_pclk = ~hsci_pclk;

  function automatic int nbytes_of(input logic [1:0] ts);
    return (ts == 2'd0) ? 1 : (ts == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [15:0] exp_cnt_value();
`ifdef HSCI_SLAVE_ERR_CNT_EN
    return 16'(exp_perr);
`else
    return 16'h0000;
`endif
  endfunction

  // One full frame: idle gap, MOSI bytes, register slave behaviour and a
  // cycle-by-cycle check of strobe, MISO and busy. delay >= TO means no ack.
  // abort_c > 0 pulls reset in that post-PAR cycle and ends the frame there.
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit bad_par,
                           input int delay, input logic [31:0] rdata,
                           input bit inject, input int gap, input int abort_c);
    int n, hdr_c, nrsp, strobes;
    bit rd, unk, access, tmo;
    logic [7:0] par, status, rpar, b, exp_m;
    logic [31:0] wd;
    n   = nbytes_of(cmd[1:0]);
    rd  = cmd[7];
    unk = |cmd[6:2];
    wd  = (n == 4) ? wdata : (wdata & ((32'h1 << (8 * n)) - 32'h1));
    frame_q.delete();
    frame_q.push_back(cmd);
    for (int i = ADDR_BYTES - 1; i >= 0; i--) frame_q.push_back(addr[8*i +: 8]);
    if (!rd) for (int i = n - 1; i >= 0; i--) frame_q.push_back(wd[8*i +: 8]);
    par = 8'h00;
    foreach (frame_q[i]) par ^= frame_q[i];
    if (bad_par) par ^= 8'h01;
    frame_q.push_back(par);

    access = !bad_par && !unk;
    tmo    = access && (delay >= TO);
    status = {5'b0, tmo, unk, bad_par};
    exp_q.delete();
    exp_q.push_back(8'h5A);
    exp_q.push_back(status);
    rpar = status;
    if (rd) begin
      for (int i = n - 1; i >= 0; i--) begin
        b = (status == 8'h00) ? rdata[8*i +: 8] : 8'h00;
        exp_q.push_back(b);
        rpar ^= b;
      end
    end
    exp_q.push_back(rpar);
    nrsp  = exp_q.size();
    hdr_c = !access ? 1 : (tmo ? 2 + TO : 3 + delay);
    if (bad_par) exp_perr++;

    for (int g = 0; g < gap; g++) begin
      @(posedge hsci_pclk); #1;
      b = 8'($urandom_range(0, 255));
      mosi_data = (b == 8'hA5) ? 8'h00 : b;
    end
    @(posedge hsci_pclk); #1;
    mosi_data = 8'hA5;
    foreach (frame_q[i]) begin
      @(posedge hsci_pclk); #1;
      mosi_data = frame_q[i];
    end

    strobes = 0;
    for (int c = 1; c <= hdr_c + nrsp; c++) begin
      @(posedge hsci_pclk); #1;
      mosi_data = (inject && rd && c == hdr_c + 2) ? 8'hA5 : 8'h00;
      if (c == 1) reg_ack = 1'($urandom_range(0, 1));
      else        reg_ack = access && !tmo && (c == 2 + delay);
      reg_rdata = (reg_ack && c != 1) ? rdata : $urandom();
      if (c == abort_c) begin
        hsci_rstn = 1'b0;
        exp_perr  = 0;
        #1;
        total++;
        if (miso_data !== 8'h00 || busy !== 1'b0 || reg_wr !== 1'b0 || reg_rd !== 1'b0) begin
          bad++;
          $display("FAIL abort_outputs: got miso=%h busy=%b wr=%b rd=%b want 00 0 0 0",
                   miso_data, busy, reg_wr, reg_rd);
        end
        total++;
        if (parity_err_cnt !== 16'h0000) begin
          bad++;
          $display("FAIL abort_errcnt: got %h want 0000", parity_err_cnt);
        end
        reg_ack = 1'b0;
        @(posedge hsci_pclk); #1;
        hsci_rstn = 1'b1;
        return;
      end
      @(negedge hsci_pclk);
      if (reg_wr || reg_rd) strobes++;
      if (c == 1 && access) begin
        total++;
        if (reg_wr !== !rd || reg_rd !== rd) begin
          bad++;
          $display("FAIL strobe_kind: got wr=%b rd=%b want wr=%b rd=%b", reg_wr, reg_rd, !rd, rd);
        end
        total++;
        if (reg_addr !== addr || reg_tsize !== cmd[1:0]) begin
          bad++;
          $display("FAIL strobe_addr: got %h/%0d want %h/%0d", reg_addr, reg_tsize, addr, cmd[1:0]);
        end
        if (!rd) begin
          total++;
          if (reg_wdata !== wd) begin
            bad++;
            $display("FAIL strobe_wdata: got %h want %h", reg_wdata, wd);
          end
        end
      end
      if (c >= hdr_c && c < hdr_c + nrsp) exp_m = exp_q.pop_front();
      else                                exp_m = 8'h00;
      total++;
      if (miso_data !== exp_m) begin
        bad++;
        $display("FAIL miso c=%0d: got %h want %h", c, miso_data, exp_m);
      end
      total++;
      if (busy !== (c < hdr_c + nrsp)) begin
        bad++;
        $display("FAIL busy c=%0d: got %b want %b", c, busy, (c < hdr_c + nrsp));
      end
    end
    reg_ack = 1'b0;
    total++;
    if (strobes != (access ? 1 : 0)) begin
      bad++;
      $display("FAIL strobe_count: got %0d want %0d", strobes, access ? 1 : 0);
    end
    total++;
    if (parity_err_cnt !== exp_cnt_value()) begin
      bad++;
      $display("FAIL parity_err_cnt: got %0d want %0d", parity_err_cnt, exp_cnt_value());
    end
  endtask

  task automatic test_reset();
    hsci_rstn = 1'b0;
    exp_perr  = 0;
    repeat (3) @(posedge hsci_pclk);
    @(negedge hsci_pclk);
    total++;
    if (miso_data !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_miso_busy: got %h %b want 00 0", miso_data, busy);
    end
    total++;
    if (reg_addr !== 32'h0 || reg_wdata !== 32'h0 || reg_tsize !== 2'd0) begin
      bad++;
      $display("FAIL reset_reg_bus: got %h %h %0d want 0 0 0", reg_addr, reg_wdata, reg_tsize);
    end
    total++;
    if (reg_wr !== 1'b0 || reg_rd !== 1'b0 || parity_err_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_strobes_cnt: got %b %b %h want 0 0 0000", reg_wr, reg_rd, parity_err_cnt);
    end
    @(posedge hsci_pclk); #1;
    hsci_rstn = 1'b1;
  endtask

  task automatic test_write_1byte();
    run_frame(8'h00, 32'h0000_0123, 32'h0000_005C, 1'b0, 2, 32'h0, 1'b0, 2, 0);
  endtask

  task automatic test_read_4byte();
    run_frame(8'h82, 32'h0000_0010, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1, 0);
  endtask

  task automatic test_parity_error();
    run_frame(8'h00, 32'h0000_0123, 32'h0000_005C, 1'b1, 0, 32'h0, 1'b0, 1, 0);
  endtask

  task automatic test_unknown();
    run_frame(8'h86, 32'h0000_0010, 32'h0, 1'b0, 0, 32'h1234_5678, 1'b0, 1, 0);
    run_frame(8'h7D, 32'h0000_0044, 32'hABCD_0102, 1'b0, 0, 32'h0, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    run_frame(8'h82, 32'h0000_0010, 32'h0, 1'b0, TO + 5, 32'h0BAD_0BAD, 1'b0, 1, 0);
    run_frame(8'h81, 32'h0000_0020, 32'h0, 1'b0, TO - 1, 32'h0000_C0DE, 1'b0, 1, 0);
    run_frame(8'h80, 32'h0000_0030, 32'h0, 1'b0, TO, 32'h0000_00EE, 1'b0, 1, 0);
  endtask

  task automatic test_reset_overlap();
    run_frame(8'h82, 32'h0000_0010, 32'h0, 1'b0, TO + 5, 32'h0, 1'b0, 1, 4);
    run_frame(8'h82, 32'h0000_0010, 32'h0, 1'b0, 1, 32'hCAFE_F00D, 1'b1, 1, 0);
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int delay;
    for (int k = 0; k < 30; k++) begin
      cmd = {1'($urandom_range(0, 1)), 5'b0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 5) == 0) cmd[6:2] = 5'($urandom_range(1, 31));
      delay = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO + 3) : $urandom_range(0, 4);
      run_frame(cmd, $urandom(), $urandom(), ($urandom_range(0, 5) == 0), delay,
                $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      run_frame({k[0], 5'b0, 2'(k)}, $urandom(), $urandom(), 1'b0, 0, $urandom(), 1'b0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_write_1byte();
    test_read_4byte();
    test_parity_error();
    test_unknown();
    test_timeout();
    test_reset_overlap();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
